bus_drvr_fifo: RTL

BUS_DRVR_FIFO -- requirements
Module: bus_drvr_fifo

---
 rtl/bus_pkg.sv | 11 +
 rtl/bus_drvr_fifo.sv | 100 ++++++++++
 2 files changed

// File: rtl/bus_pkg.sv
// Shared bus-side definitions: default packet width, default driver FIFO
// depth and the width of the optional statistics counters. The bus driver
// FIFO and the generator/arbiter both pull their defaults from here so the
// two ends of the bus always agree on the word size.
package bus_pkg;

  localparam int PCKG_DEF  = 16;
  localparam int DEPTH_DEF = 4;
  localparam int STAT_W    = 16;

endpackage

// File: rtl/bus_drvr_fifo.sv
// Bus driver FIFO: one instance per agent. The agent pushes packets; the
// generator/arbiter sees pndng/D_pop (first-word-fall-through) and pops.
// Overflow drops the incoming packet; popping an empty FIFO is ignored.
// Both events latch sticky flags that only reset clears.
// Optional build macro BUS_DRVR_FIFO_STATS_EN adds saturating push/pop/drop
// counters as extra outputs.
module bus_drvr_fifo
  import bus_pkg::*;
#(
  parameter int PCKG  = PCKG_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [PCKG-1:0]             D_push,
  output logic                        full,
  input  logic                        pop,
  output logic [PCKG-1:0]             D_pop,
  output logic                        pndng,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        ovf,
  output logic                        udf
`ifdef BUS_DRVR_FIFO_STATS_EN
  ,
  output logic [STAT_W-1:0]           push_cnt,
  output logic [STAT_W-1:0]           pop_cnt,
  output logic [STAT_W-1:0]           drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PCKG-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_acc;
  logic            pop_acc;
  logic            push_drop;
  logic            pop_empty;

  // Flags are pure decodes of the registered count, so no combinational path
  // exists from push/pop to full/pndng/count.
  assign full  = (count == CW'(DEPTH));
  assign pndng = (count != '0);

  // A push while full still fits when a pop frees the head slot in the same
  // cycle; a pop while empty never takes the packet being pushed.
  assign push_acc  = push && (!full || pop);
  assign pop_acc   = pop && pndng;
  assign push_drop = push && full && !pop;
  assign pop_empty = pop && !pndng;

  // Head packet is forced to zero whenever nothing is pending.
  assign D_pop = pndng ? mem[rd_ptr] : '0;

  // Packet storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= D_push;
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      if (push_acc && !pop_acc)      count <= count + CW'(1);
      else if (!push_acc && pop_acc) count <= count - CW'(1);
      if (push_drop) ovf <= 1'b1;
      if (pop_empty) udf <= 1'b1;
    end
  end

`ifdef BUS_DRVR_FIFO_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

  // Saturating event counters for accepted pushes, accepted pops and drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_acc)  push_cnt <= sat_inc(push_cnt);
      if (pop_acc)   pop_cnt  <= sat_inc(pop_cnt);
      if (push_drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule
